// File: rtl/load_store_unit.sv
// RV32I memory-access stage: byte/half/word loads and stores over a word-wide
// request/acknowledge bus, with alignment/funct3 checking and a bus timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [31:0] TO_W = 32'(TIMEOUT_CYCLES);
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] load_data_q, load_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_byteen_q, mem_byteen_d;

  logic        illegal, misaligned;
  logic [31:0] shifted, extended;

  always_comb begin
    if (is_store) illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
    else          illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  extended = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  extended = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  extended = {24'd0, shifted[7:0]};
      3'b101:  extended = {16'd0, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    load_data_d  = load_data_q;
    fault_d      = 1'b0;
    cause_d      = 2'd0;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_byteen_d = mem_byteen_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          funct3_d = funct3;
          lane_d   = addr[1:0];
          if (illegal || misaligned) begin
            state_d = S_RESP;
            fault_d = 1'b1;
            cause_d = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
          end else begin
            state_d     = S_BUS;
            cnt_d       = '0;
            mem_write_d = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            case (funct3[1:0])
              2'b00: begin
                mem_wdata_d  = {4{store_data[7:0]}};
                mem_byteen_d = 4'b0001 << addr[1:0];
              end
              2'b01: begin
                mem_wdata_d  = {2{store_data[15:0]}};
                mem_byteen_d = 4'b0011 << addr[1:0];
              end
              default: begin
                mem_wdata_d  = store_data;
                mem_byteen_d = 4'b1111;
              end
            endcase
            if (!is_store) mem_byteen_d = '0;
          end
        end
      end
      S_BUS: begin
        // Ack is checked before the timeout so a same-cycle ack still succeeds.
        if (mem_ack) begin
          state_d      = S_RESP;
          mem_write_d  = 1'b0;
          mem_byteen_d = '0;
          if (!mem_write_q) load_data_d = extended;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q + 32'd1 == TO_W)) begin
          state_d      = S_RESP;
          fault_d      = 1'b1;
          cause_d      = CAUSE_TIMEOUT;
          mem_write_d  = 1'b0;
          mem_byteen_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_RESP);
    mem_req_d = (state_d == S_BUS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      funct3_q     <= '0;
      lane_q       <= '0;
      load_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      cause_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_byteen_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      load_data_q  <= load_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_byteen_q <= mem_byteen_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign load_data   = load_data_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign mem_req     = mem_req_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_byteen  = mem_byteen_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single accesses plus hand-written
// reset-mid-access and start-while-busy sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .load_data(load_data), .fault(fault),
    .fault_cause(fault_cause), .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    int          ack_at;   // edge index (after start) at which ack is seen; 0 = never
    logic [31:0] rdata;
    int          lat;      // cycle index in which done is high
    int          reqc;     // number of cycles with mem_req high
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] load;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  lat = 0;
    int  reqc = 0;
    bit  first = 1'b1;
    @(negedge clk);
    start = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.addr; store_data = v.sdata;
    mem_ack = 1'b0; mem_rdata = v.rdata;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (mem_req) begin
        reqc++;
        if (first) begin
          chk({tag, " mem_addr"},  mem_addr, v.maddr);
          chk({tag, " mem_write"}, {31'd0, mem_write}, {31'd0, v.st});
          chk({tag, " byteen"},    {28'd0, mem_byteen}, {28'd0, v.be});
          if (v.st) chk({tag, " wdata"}, mem_wdata, v.wdata);
          first = 1'b0;
        end
      end
      if (done) begin
        lat = n;
        chk({tag, " fault"}, {31'd0, fault}, {31'd0, v.fault});
        chk({tag, " cause"}, {30'd0, fault_cause}, {30'd0, v.cause});
        chk({tag, " load_data"}, load_data, v.load);
      end
      mem_ack = (v.ack_at == n);
    end
    mem_ack = 1'b0;
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " req_cycles"}, reqc, v.reqc);
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int dones;
    vec_t v;
    //            st  f3      addr          sdata         ack rdata         lat req flt cause load          maddr         wdata         be
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        3, 32'hDEADBEEF, 4, 3, 1'b0, 2'd0, 32'hDEADBEEF, 32'h0000_0100, 32'h0,        4'b0000};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0203, 32'h0,        1, 32'h80123456, 2, 1, 1'b0, 2'd0, 32'hFFFFFF80, 32'h0000_0200, 32'h0,        4'b0000};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0203, 32'h0,        1, 32'h80123456, 2, 1, 1'b0, 2'd0, 32'h00000080, 32'h0000_0200, 32'h0,        4'b0000};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0202, 32'h0,        2, 32'h80015555, 3, 2, 1'b0, 2'd0, 32'hFFFF8001, 32'h0000_0200, 32'h0,        4'b0000};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0202, 32'h0,        2, 32'h80015555, 3, 2, 1'b0, 2'd0, 32'h00008001, 32'h0000_0200, 32'h0,        4'b0000};
    vecs[5]  = '{1'b1, 3'b001, 32'h0000_0002, 32'h1234ABCD, 1, 32'h0,        2, 1, 1'b0, 2'd0, 32'h00008001, 32'h0000_0000, 32'hABCDABCD, 4'b1100};
    vecs[6]  = '{1'b1, 3'b000, 32'h0000_0001, 32'h0000005A, 1, 32'h0,        2, 1, 1'b0, 2'd0, 32'h00008001, 32'h0000_0000, 32'h5A5A5A5A, 4'b0010};
    vecs[7]  = '{1'b0, 3'b010, 32'h0000_1002, 32'h0,        1, 32'h0,        1, 0, 1'b1, 2'd1, 32'h00008001, 32'h0,         32'h0,        4'b0000};
    vecs[8]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        1, 32'h0,        1, 0, 1'b1, 2'd2, 32'h00008001, 32'h0,         32'h0,        4'b0000};
    vecs[9]  = '{1'b1, 3'b100, 32'h0000_0000, 32'h0,        1, 32'h0,        1, 0, 1'b1, 2'd2, 32'h00008001, 32'h0,         32'h0,        4'b0000};
    vecs[10] = '{1'b0, 3'b101, 32'h0000_0203, 32'h0,        1, 32'h0,        1, 0, 1'b1, 2'd1, 32'h00008001, 32'h0,         32'h0,        4'b0000};
    vecs[11] = '{1'b0, 3'b111, 32'h0000_0003, 32'h0,        1, 32'h0,        1, 0, 1'b1, 2'd2, 32'h00008001, 32'h0,         32'h0,        4'b0000};
    vecs[12] = '{1'b0, 3'b010, 32'h0000_0300, 32'h0,        0, 32'h0,        5, 4, 1'b1, 2'd3, 32'h00008001, 32'h0000_0300, 32'h0,        4'b0000};
    vecs[13] = '{1'b0, 3'b010, 32'h0000_0300, 32'h0,        4, 32'hCAFEF00D, 5, 4, 1'b0, 2'd0, 32'hCAFEF00D, 32'h0000_0300, 32'h0,        4'b0000};
    vecs[14] = '{1'b1, 3'b010, 32'h0000_0010, 32'h11223344, 1, 32'h0,        2, 1, 1'b0, 2'd0, 32'hCAFEF00D, 32'h0000_0010, 32'h11223344, 4'b1111};

    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0;
    store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy",      {31'd0, busy}, 32'd0);
    chk("rst done",      {31'd0, done}, 32'd0);
    chk("rst fault",     {29'd0, fault, fault_cause}, 32'd0);
    chk("rst load_data", load_data, 32'd0);
    chk("rst mem_req",   {30'd0, mem_req, mem_write}, 32'd0);
    chk("rst mem_addr",  mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst byteen",    {28'd0, mem_byteen}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset during BUS, then a late ack while idle.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("rstmid req_before", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid req_after",  {31'd0, mem_req}, 32'd0);
    chk("rstmid busy_after", {31'd0, busy}, 32'd0);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
    dones = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (done) dones++;
    end
    chk("rstmid no_done", dones, 0);
    chk("rstmid load_data", load_data, 32'd0);
    v = '{1'b0, 3'b010, 32'h44, 32'h0, 2, 32'h0BADF00D, 3, 2, 1'b0, 2'd0, 32'h0BADF00D, 32'h44, 32'h0, 4'b0000};
    run_vec(v, "post_rst");

    // start pulsed while busy must be ignored.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80; mem_rdata = 32'h76543210;
    @(posedge clk);
    @(negedge clk);
    is_store = 1'b1; addr = 32'h3;
    dones = 0;
    for (int n = 1; n <= 10; n++) begin
      if (n > 1) @(negedge clk);
      start = (n <= 2);
      if (mem_req) chk($sformatf("busy_start addr c%0d", n), mem_addr, 32'h80);
      if (done) begin
        dones++;
        chk("busy_start fault", {29'd0, fault, fault_cause}, 32'd0);
        chk("busy_start load",  load_data, 32'h76543210);
      end
      mem_ack = (n == 3);
    end
    mem_ack = 1'b0;
    chk("busy_start one_done", dones, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RV32I core. It sits directly downstream of the ALU and consumes the effective address (ALU result, `OP_LOAD`/`OP_STORE` path) plus rs2 store data. It performs byte, half or word accesses over a word-wide request/acknowledge data bus. Load results are returned to the write-back mux as the `DEST_REG_FROM_MEM` source, sign- or zero-extended.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles waiting for `mem_ack`; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin an access; sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load
- `funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- `addr`  in  32  byte address from ALU
- `store_data`  in  32  rs2 value
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle completion pulse
- `load_data`  out  32  extended load result, valid from `done`
- `fault`  out  1  high with `done` when the access failed
- `fault_cause`  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 bus timeout
- `mem_req`  out  1  bus request
- `mem_write`  out  1  1 = write cycle
- `mem_addr`  out  32  word-aligned address ({addr[31:2], 2'b00})
- `mem_wdata`  out  32  lane-replicated store data
- `mem_byteen`  out  4  byte enables (writes only; 4'b0000 on reads)
- `mem_ack`  in  1  bus acknowledge; `mem_rdata` valid the same cycle
- `mem_rdata`  in  32  read word

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE + `start`:
  - Latch `is_store`, `funct3`, `addr`, `store_data`.
  - Valid and aligned → BUS. Otherwise → RESP with fault.
- Illegal `funct3`: 011, 110, 111 for loads; any value other than 000/001/010 for stores. Cause 2.
- Misaligned: H/HU with addr[0]=1, W with addr[1:0]≠0. Cause 1. Illegal takes priority over misaligned.
- BUS:
  - `mem_req`=1; address, data, byteen and write are stable until ack.
  - On `mem_ack` → RESP. Loads capture the extended data.
- Timeout: a counter clears on BUS entry and increments each BUS cycle without ack. On reaching `TIMEOUT_CYCLES` → RESP, cause 3, `mem_req` deasserted.
- Ack and timeout in the same cycle: ack wins.
- RESP: `done`=1, `fault`/`fault_cause` driven; → IDLE unconditionally.
- `start` outside IDLE is ignored (no queueing).
- Lane = addr[1:0].
  - Load: shift `mem_rdata` right by 8·lane; B/H sign-extend bit 7/15; BU/HU zero-extend.
  - Store B: wdata={4{data[7:0]}}, byteen=4'b0001<<lane.
  - Store H: wdata={2{data[15:0]}}, byteen=4'b0011<<lane.
  - Store W: wdata=data, byteen=4'b1111.
- `load_data` updates only on a successful load. It holds otherwise, including across stores and faults.

## Timing
- Reset (`rst_n`=0 at an edge) forces: state IDLE, `busy`=0, `done`=0, `fault`=0, `fault_cause`=0, `load_data`=0, `mem_req`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `mem_byteen`=0, timeout counter 0.
- Reset mid-access: `mem_req` drops at the reset edge, no `done` is issued, and a late `mem_ack` is ignored.
- All outputs are registered.
- Success path:
  - `start` accepted at edge 0; `mem_req` high from edge 0.
  - `mem_ack` seen at edge k (k≥1) → `done` high for the cycle after edge k.
  - Minimum latency start→done is 2 cycles.
- Fault path (misaligned/illegal): `done`+`fault` for the cycle after edge 0 (1-cycle latency); `mem_req` never asserts.
- Timeout: `done`+`fault` one cycle after the TIMEOUT_CYCLES-th unacked BUS cycle.
- Earliest next `start` acceptance: the edge after the `done` cycle.

## Test plan
- LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF → mem_addr 0x100, byteen 0000, load_data 0xDEADBEEF, done 4 cycles after start, fault 0.
- LB addr 0x203, rdata 0x80123456 → load_data 0xFFFFFF80. Same with LBU → 0x00000080. LH addr 0x202 rdata 0x8001xxxx → 0xFFFF8001.
- SH addr 0x2, store_data 0x1234ABCD, ack immediately → mem_write 1, mem_addr 0x0, wdata 0xABCDABCD, byteen 1100, done next cycle. SB addr 0x1 data 0x5A → wdata 0x5A5A5A5A, byteen 0010.
- LW addr 0x1002 → mem_req never high, done+fault cycle after start, cause 1. Load funct3 011 → cause 2. Store funct3 100 → cause 2.
- TIMEOUT_CYCLES=4, no ack → mem_req high exactly 4 cycles then low, done+fault cause 3, load_data unchanged. Ack on the 4th cycle → success.
- Assert `rst_n` low during BUS, then ack arrives → no done, mem_req 0 after the reset edge. A subsequent LW completes normally. `start` pulsed while busy → ignored, exactly one done.
